// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package if_stage_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned IF_FIFO_DEPTH    = 2;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Two-entry prefetch FIFO of {pc, instr} with flush; push and pop may coincide.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int unsigned DEPTH = IF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign valid   = (count != 2'd0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != FULL) || do_pop);

    // Pointer, occupancy and storage update; flush empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches under a 2-credit limit,
// buffers returned words in a prefetch FIFO and feeds the decoder.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o
);

    logic         started_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  resp_pc_q;
    logic [31:0]  last_pc_q;
    logic [1:0]   outstanding_q;
    logic [1:0]   outstanding_nxt;
    logic [1:0]   discard_q;
    logic [1:0]   fifo_count;
    logic [2:0]   credit_used;
    logic         granted;
    logic         push;
    logic         pop;
    logic         fifo_valid;
    fetch_entry_t fifo_head;
    fetch_entry_t push_data;
    logic [31:0]  redirect_target;

    assign redirect_target = word_align(redirect_pc_i);
    assign credit_used     = 3'(fifo_count) + 3'(outstanding_q);
    assign imem_req_o      = started_q && !redirect_i && (credit_used < 3'd2);
    assign imem_addr_o     = fetch_pc_q;
    assign granted         = imem_req_o && imem_gnt_i;

    // Responses arrive in order, so the pc of the next kept response is a
    // running counter rather than a per-request tag.
    assign push            = imem_rvalid_i && !redirect_i && (discard_q == 2'd0);
    assign push_data.pc    = resp_pc_q;
    assign push_data.instr = imem_rdata_i;
    assign pop             = fifo_valid && !stall_i && !redirect_i;

    assign instr_valid_o   = fifo_valid;
    assign instruction_o   = fifo_valid ? fifo_head.instr : INSTR_NOP;
    assign pc_o            = fifo_valid ? fifo_head.pc : last_pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    // In-flight request count after this cycle's grant and response.
    always_comb begin
        outstanding_nxt = outstanding_q;
        if (granted && !imem_rvalid_i) begin
            outstanding_nxt = outstanding_q + 2'd1;
        end else if (!granted && imem_rvalid_i) begin
            outstanding_nxt = outstanding_q - 2'd1;
        end
    end

    // Fetch and response pointers, credit and discard bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            last_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else begin
            started_q     <= 1'b1;
            outstanding_q <= outstanding_nxt;
            if (fifo_valid) begin
                last_pc_q <= fifo_head.pc;
            end
            if (redirect_i) begin
                fetch_pc_q <= redirect_target;
                resp_pc_q  <= redirect_target;
                discard_q  <= outstanding_nxt;
            end else begin
                if (granted) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (imem_rvalid_i && (discard_q != 2'd0)) begin
                    discard_q <= discard_q - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: randomised memory timing and control,
// checked against a queue-based model of the fetch stream.
module tb_if_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_valid_o (instr_valid_o),
        .instruction_o (instruction_o),
        .pc_o          (pc_o)
    );

    // Model: granted-but-unreturned requests, and the instructions the
    // decoder should see, in order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ins_t;

    req_t        pend[$];
    ins_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned since_rst = 0;
    int unsigned last_due = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned total_consumed = 0;
    logic [31:0] exp_fetch_pc = RST_PC;
    logic [31:0] last_pc = RST_PC;
    logic        consumed = 1'b0;
    logic [31:0] consumed_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic rv_due();
        return (pend.size() != 0) && (pend[0].due <= cyc);
    endfunction

    // One clock of stimulus plus model checks on the DUT outputs.
    task automatic cycle(input logic s, input logic r, input logic [31:0] rp);
        logic        rv;
        logic        granted;
        logic        do_pop;
        logic        exp_req;
        logic [31:0] addr_seen;
        int unsigned lat;
        int unsigned due;
        req_t        e_req;
        ins_t        e_ins;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = rp;
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        rv            = rv_due();
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
        #1;
        exp_req = (since_rst >= 1) && !r && ((pend.size() + exp_q.size()) < 2);
        checks++;
        if (imem_req_o !== exp_req) begin
            errors++;
            $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req_o, exp_req);
        end
        checks++;
        if (imem_addr_o !== exp_fetch_pc) begin
            errors++;
            $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, exp_fetch_pc);
        end
        checks++;
        if (instr_valid_o !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, instr_valid_o, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (pc_o !== exp_q[0].pc) begin
                errors++;
                $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, pc_o, exp_q[0].pc);
            end
            checks++;
            if (instruction_o !== exp_q[0].instr) begin
                errors++;
                $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instruction_o, exp_q[0].instr);
            end
            last_pc = exp_q[0].pc;
        end else begin
            checks++;
            if (instruction_o !== NOP) begin
                errors++;
                $display("FAIL nop cyc=%0d got=%h exp=%h", cyc, instruction_o, NOP);
            end
            checks++;
            if (pc_o !== last_pc) begin
                errors++;
                $display("FAIL held_pc cyc=%0d got=%h exp=%h", cyc, pc_o, last_pc);
            end
        end
        granted   = imem_req_o && imem_gnt_i;
        addr_seen = imem_addr_o;
        do_pop    = (exp_q.size() != 0) && !s && !r;
        consumed  = do_pop;
        if (do_pop) begin
            consumed_pc = exp_q[0].pc;
            total_consumed++;
        end
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (rv) begin
            e_req = pend.pop_front();
            if (!r && e_req.epoch == epoch) begin
                e_ins.pc    = e_req.pc;
                e_ins.instr = mem_word(e_req.pc);
                exp_q.push_back(e_ins);
            end
        end
        if (r) begin
            exp_q.delete();
            epoch++;
            exp_fetch_pc = rp & ~32'h3;
        end else if (granted) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due    = due;
            e_req.pc    = exp_fetch_pc;
            e_req.addr  = addr_seen;
            e_req.epoch = epoch;
            e_req.due   = due;
            pend.push_back(e_req);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        cyc++;
        since_rst++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        pend.delete();
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        last_pc      = RST_PC;
        since_rst    = 0;
        rst_n        = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        imem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #1;
            checks++;
            if (imem_req_o !== 1'b0 || imem_addr_o !== RST_PC || instr_valid_o !== 1'b0
                || instruction_o !== NOP || pc_o !== RST_PC) begin
                errors++;
                $display("FAIL reset_outputs req=%b addr=%h valid=%b instr=%h pc=%h exp 0/%h/0/%h/%h",
                         imem_req_o, imem_addr_o, instr_valid_o, instruction_o, pc_o,
                         RST_PC, NOP, RST_PC);
            end
        end
        @(negedge clk);
        pend.delete();
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        last_pc      = RST_PC;
        since_rst    = 0;
        rst_n        = 1'b1;
        gnt_pct      = 100;
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_stream();
        int          first_valid;
        logic [31:0] first_pc;
        logic [31:0] nxt;
        int unsigned got;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        first_valid = -1; first_pc = 'x; nxt = RST_PC; got = 0;
        for (int i = 0; i < 40; i++) begin
            if (first_valid < 0 && instr_valid_o === 1'b1) begin
                first_valid = i;
                first_pc    = pc_o;
            end
            cycle(1'b0, 1'b0, '0);
            if (consumed) begin
                checks++;
                if (consumed_pc !== nxt) begin
                    errors++;
                    $display("FAIL stream_order got=%h exp=%h", consumed_pc, nxt);
                end
                nxt = nxt + 32'd4;
                got++;
            end
        end
        checks++;
        if (first_valid != 3 || first_pc !== RST_PC) begin
            errors++;
            $display("FAIL first_valid cycle=%0d pc=%h exp cycle=3 pc=%h", first_valid, first_pc, RST_PC);
        end
        checks++;
        if (got < 10) begin
            errors++;
            $display("FAIL stream_count got=%0d exp>=10", got);
        end
    endtask

    task automatic test_stall();
        logic [31:0] fz_pc;
        logic [31:0] fz_ins;
        logic [31:0] nxt;
        int unsigned got;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 2;
        for (int i = 0; i < 20 && instr_valid_o !== 1'b1; i++) cycle(1'b0, 1'b0, '0);
        checks++;
        if (instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup valid=%b exp=1", instr_valid_o);
        end
        fz_pc  = pc_o;
        fz_ins = instruction_o;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (pc_o !== fz_pc || instruction_o !== fz_ins || instr_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_frozen pc=%h instr=%h got vs exp pc=%h instr=%h",
                         pc_o, instruction_o, fz_pc, fz_ins);
            end
            checks++;
            if (pend.size() + exp_q.size() > 2) begin
                errors++;
                $display("FAIL stall_credits inflight=%0d exp<=2", pend.size() + exp_q.size());
            end
        end
        nxt = fz_pc; got = 0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (consumed) begin
                checks++;
                if (consumed_pc !== nxt) begin
                    errors++;
                    $display("FAIL stall_release_order got=%h exp=%h", consumed_pc, nxt);
                end
                nxt = nxt + 32'd4;
                got++;
            end
        end
        checks++;
        if (got < 8) begin
            errors++;
            $display("FAIL stall_release_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_redirect();
        logic        found;
        logic [31:0] nxt;
        int unsigned got;
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2) found = 1'b1;
            else cycle(1'b0, 1'b0, '0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_setup outstanding=%0d exp=2", pend.size());
        end
        cycle(1'b0, 1'b1, 32'h0000_0100);
        nxt = 32'h0000_0100; got = 0;
        for (int i = 0; i < 40 && got < 2; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (consumed) begin
                checks++;
                if (consumed_pc !== nxt) begin
                    errors++;
                    $display("FAIL redirect_order got=%h exp=%h", consumed_pc, nxt);
                end
                nxt = nxt + 32'd4;
                got++;
            end
        end
        checks++;
        if (got < 2) begin
            errors++;
            $display("FAIL redirect_count got=%0d exp=2", got);
        end
    endtask

    task automatic test_unaligned();
        do_reset();
        gnt_pct = 0;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0203);
        redirect_i = 1'b0;
        #1;
        checks++;
        if (imem_addr_o !== 32'h0000_0200 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL unaligned addr=%h req=%b exp addr=00000200 req=1", imem_addr_o, imem_req_o);
        end
        gnt_pct = 100; lat_min = 1; lat_max = 2;
        repeat (10) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_rv_stall_redirect();
        logic found;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (rv_due() && instr_valid_o === 1'b1) begin
                found = 1'b1;
                cycle(1'b1, 1'b1, 32'h0000_0300);
                checks++;
                if (instr_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rv_stall_redirect valid=%b exp=0", instr_valid_o);
                end
            end else begin
                cycle(1'b0, 1'b0, '0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rv_stall_setup found=0 exp=1");
        end
        repeat (10) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_gnt_low();
        logic [31:0] addr0;
        do_reset();
        gnt_pct = 0;
        cycle(1'b0, 1'b0, '0);
        addr0 = exp_fetch_pc;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== addr0 || instruction_o !== NOP) begin
                errors++;
                $display("FAIL gnt_low req=%b addr=%h instr=%h exp 1/%h/%h",
                         imem_req_o, imem_addr_o, instruction_o, addr0, NOP);
            end
            cycle(1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_random();
        int unsigned start;
        do_reset();
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        start = total_consumed;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 30, $urandom_range(99) < 3, $urandom);
        end
        checks++;
        if (total_consumed - start < 100) begin
            errors++;
            $display("FAIL random_progress consumed=%0d exp>=100", total_consumed - start);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_unaligned();
        test_rv_stall_redirect();
        test_gnt_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout sim_time=%0t limit=1000000", $time);
        $fatal(1, "timeout");
    end

endmodule
